// File: rtl/sdram_sched_pkg.sv
// rtl/sdram_sched_pkg.sv - shared state and operation encodings for the SDRAM page scheduler
package sdram_sched_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_RFO = 2'd0,
        ST_IDLE     = 2'd1,
        ST_ISSUE    = 2'd2,
        ST_BUSY     = 2'd3
    } state_t;

    localparam logic [1:0] OP_NONE    = 2'd0;
    localparam logic [1:0] OP_WRITE   = 2'd1;
    localparam logic [1:0] OP_READ    = 2'd2;
    localparam logic [1:0] OP_REFRESH = 2'd3;

endpackage

// File: rtl/sdram_sched_arb.sv
// rtl/sdram_sched_arb.sv - combinational refresh/write/read pick with read anti-starvation
module sdram_sched_arb
    import sdram_sched_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int SW           = 3
) (
    input  logic          ref_elig,
    input  logic          wr_elig,
    input  logic          rd_elig,
    input  logic [SW-1:0] wr_streak,
    output logic [1:0]    pick
);

    // Refresh always first; writes favoured until the streak saturates, then one read gets through
    always_comb begin
        pick = OP_NONE;
        if (ref_elig) begin
            pick = OP_REFRESH;
        end else if (wr_elig && rd_elig) begin
            pick = (wr_streak == SW'(STARVE_LIMIT)) ? OP_READ : OP_WRITE;
        end else if (wr_elig) begin
            pick = OP_WRITE;
        end else if (rd_elig) begin
            pick = OP_READ;
        end
    end

endmodule

// File: rtl/sdram_page_scheduler.sv
// rtl/sdram_page_scheduler.sv - circular page buffer scheduler issuing one SDRAM operation at a time
module sdram_page_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int PAGE_AW      = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ctl_rfo,
    input  logic               wr_req,
    input  logic               rd_req,
    input  logic               ref_req,
    output logic               op_valid,
    input  logic               op_ready,
    output logic [1:0]         op_kind,
    output logic [PAGE_AW-1:0] op_page,
    input  logic               op_done,
    output logic               wr_done,
    output logic               rd_done,
    output logic               ref_ack,
    output logic [PAGE_AW:0]   level,
    output logic               full,
    output logic               empty,
    output logic               err
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [PAGE_AW:0]   DEPTH    = {1'b1, {PAGE_AW{1'b0}}};
    localparam logic [PAGE_AW:0]   LVL_ONE  = {{PAGE_AW{1'b0}}, 1'b1};
    localparam logic [PAGE_AW-1:0] PTR_ONE  = {{(PAGE_AW-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0]      STK_ONE  = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0]      STK_MAX  = SW'(STARVE_LIMIT);

    state_t             state;
    state_t             state_nx;
    logic [1:0]         kind_r;
    logic [PAGE_AW-1:0] page_r;
    logic [PAGE_AW-1:0] wr_ptr;
    logic [PAGE_AW-1:0] rd_ptr;
    logic [PAGE_AW:0]   level_r;
    logic [SW-1:0]      wr_streak;
    logic               wr_elig;
    logic               rd_elig;
    logic [1:0]         pick;
    logic               grant;
    logic               finish;

    assign full    = (level_r == DEPTH);
    assign empty   = (level_r == '0);
    assign level   = level_r;
    assign wr_elig = wr_req && !full;
    assign rd_elig = rd_req && !empty;

    // A pick only counts in IDLE with the controller up; completion only counts in BUSY with it up
    assign grant  = (state == ST_IDLE) && ctl_rfo && (pick != OP_NONE);
    assign finish = (state == ST_BUSY) && ctl_rfo && op_done;

    sdram_sched_arb #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .SW           (SW)
    ) u_arb (
        .ref_elig  (ref_req),
        .wr_elig   (wr_elig),
        .rd_elig   (rd_elig),
        .wr_streak (wr_streak),
        .pick      (pick)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_WAIT_RFO;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and operation presentation; losing ctl_rfo abandons whatever is in flight
    always_comb begin
        state_nx = state;
        op_valid = 1'b0;
        op_kind  = OP_NONE;
        op_page  = '0;
        if (!ctl_rfo) begin
            state_nx = ST_WAIT_RFO;
        end else begin
            case (state)
                ST_WAIT_RFO: state_nx = ST_IDLE;
                ST_IDLE:     if (pick != OP_NONE) state_nx = ST_ISSUE;
                ST_ISSUE:    if (op_ready) state_nx = ST_BUSY;
                ST_BUSY:     if (op_done) state_nx = ST_IDLE;
                default:     state_nx = ST_WAIT_RFO;
            endcase
        end
        if (state == ST_ISSUE) begin
            op_valid = 1'b1;
            op_kind  = kind_r;
            op_page  = page_r;
        end
    end

    // Latch the chosen operation and its target page at grant time so they stay stable in ISSUE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kind_r <= OP_NONE;
            page_r <= '0;
        end else if (grant) begin
            kind_r <= pick;
            case (pick)
                OP_WRITE: page_r <= wr_ptr;
                OP_READ:  page_r <= rd_ptr;
                default:  page_r <= '0;
            endcase
        end
    end

    // Count writes that won against a waiting read; any read grant resets the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_streak <= '0;
        end else if (grant) begin
            if (pick == OP_READ) begin
                wr_streak <= '0;
            end else if (pick == OP_WRITE && rd_elig && wr_streak != STK_MAX) begin
                wr_streak <= wr_streak + STK_ONE;
            end
        end
    end

    // Pointer, fill level and completion pulses advance only when a BUSY operation completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_r <= '0;
            wr_done <= 1'b0;
            rd_done <= 1'b0;
            ref_ack <= 1'b0;
        end else begin
            wr_done <= finish && (kind_r == OP_WRITE);
            rd_done <= finish && (kind_r == OP_READ);
            ref_ack <= finish && (kind_r == OP_REFRESH);
            if (finish && kind_r == OP_WRITE) begin
                wr_ptr  <= wr_ptr + PTR_ONE;
                level_r <= level_r + LVL_ONE;
            end else if (finish && kind_r == OP_READ) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                level_r <= level_r - LVL_ONE;
            end
        end
    end

    // Sticky flag for a completion that arrives when nothing is executing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (op_done && state != ST_BUSY) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_page_scheduler.sv
// tb/tb_sdram_page_scheduler.sv - self-checking bench for sdram_page_scheduler
module tb_sdram_page_scheduler;

    localparam int AW    = 3;
    localparam int NPG   = 1 << AW;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ctl_rfo;
    logic          wr_req;
    logic          rd_req;
    logic          ref_req;
    logic          op_valid;
    logic          op_ready;
    logic [1:0]    op_kind;
    logic [AW-1:0] op_page;
    logic          op_done;
    logic          wr_done;
    logic          rd_done;
    logic          ref_ack;
    logic [AW:0]   level;
    logic          full;
    logic          empty;
    logic          err;

    int total = 0;
    int bad   = 0;

    int m_level  = 0;
    int m_wp     = 0;
    int m_rp     = 0;
    int m_streak = 0;

    sdram_page_scheduler #(
        .PAGE_AW      (AW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ctl_rfo  (ctl_rfo),
        .wr_req   (wr_req),
        .rd_req   (rd_req),
        .ref_req  (ref_req),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_kind  (op_kind),
        .op_page  (op_page),
        .op_done  (op_done),
        .wr_done  (wr_done),
        .rd_done  (rd_done),
        .ref_ack  (ref_ack),
        .level    (level),
        .full     (full),
        .empty    (empty),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference decision: what the next operation must be, given requests and the buffer contents
    task automatic m_decide(input bit r, input bit w, input bit d, output int k, output int p);
        bit we;
        bit re;
        we = w && (m_level < NPG);
        re = d && (m_level > 0);
        if (r)              k = 3;
        else if (we && re)  k = (m_streak == LIMIT) ? 2 : 1;
        else if (we)        k = 1;
        else if (re)        k = 2;
        else                k = 0;
        p = (k == 1) ? m_wp : (k == 2) ? m_rp : 0;
        if (k == 2) m_streak = 0;
        else if (k == 1 && re && m_streak < LIMIT) m_streak++;
    endtask

    task automatic m_commit(input int k);
        if (k == 1) begin
            m_wp = (m_wp + 1) % NPG;
            m_level++;
        end else if (k == 2) begin
            m_rp = (m_rp + 1) % NPG;
            m_level--;
        end
    endtask

    function automatic logic [2:0] m_pulses(input int k);
        return (k == 1) ? 3'b001 : (k == 2) ? 3'b010 : (k == 3) ? 3'b100 : 3'b000;
    endfunction

    // Drive one operation through the handshake and report what was observed
    task automatic do_op(input int acc_d, input int busy_d, input bit drop,
                         output logic [1:0] k, output logic [AW-1:0] p,
                         output logic [2:0] pulses, output bit to);
        int n;
        n = 0;
        to = 1'b0;
        k = '0;
        p = '0;
        pulses = '0;
        while (op_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (op_valid !== 1'b1) begin
            to = 1'b1;
            return;
        end
        k = op_kind;
        p = op_page;
        if (drop) begin
            wr_req = 1'b0;
            rd_req = 1'b0;
        end
        repeat (acc_d) tick();
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        repeat (busy_d) tick();
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        pulses = {ref_ack, rd_done, wr_done};
    endtask

    task automatic test_reset;
        int k;
        int p;
        bit seen;
        logic [1:0] ok;
        logic [AW-1:0] op;
        logic [2:0] pl;
        bit to;
        rst = 1'b1; ctl_rfo = 1'b0; wr_req = 1'b1; rd_req = 1'b0; ref_req = 1'b0;
        op_ready = 1'b0; op_done = 1'b0;
        repeat (3) tick();
        total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL reset_op_valid got=%0b exp=0", op_valid); end
        total++; if (op_kind !== 2'd0) begin bad++; $display("FAIL reset_op_kind got=%0d exp=0", op_kind); end
        total++; if (op_page !== '0) begin bad++; $display("FAIL reset_op_page got=%0d exp=0", op_page); end
        total++; if ({wr_done, rd_done, ref_ack} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b exp=000", {wr_done, rd_done, ref_ack}); end
        total++; if (level !== '0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        total++; if ({empty, full, err} !== 3'b100) begin bad++; $display("FAIL reset_flags got=%b exp=100", {empty, full, err}); end
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (op_valid !== 1'b0) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL rfo_low_no_valid got=1 exp=0"); end
        ctl_rfo = 1'b1;
        tick();
        total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL idle_first_cycle_valid got=%0b exp=0", op_valid); end
        m_decide(0, 1, 0, k, p);
        tick();
        total++; if (op_valid !== 1'b1) begin bad++; $display("FAIL first_issue_valid got=%0b exp=1", op_valid); end
        total++; if (op_kind !== 2'(k) || op_page !== AW'(p)) begin bad++; $display("FAIL first_issue kind/page got=%0d/%0d exp=%0d/%0d", op_kind, op_page, k, p); end
        do_op(0, 2, 0, ok, op, pl, to);
        m_commit(k);
        total++; if (to || pl !== 3'b001) begin bad++; $display("FAIL first_wr_done got=%b timeout=%0b exp=001", pl, to); end
        total++; if (level !== 4'(m_level) || level !== 4'd1) begin bad++; $display("FAIL first_level got=%0d exp=1", level); end
    endtask

    task automatic test_fill_wrap;
        int k;
        int p;
        bit seen;
        logic [1:0] ok;
        logic [AW-1:0] op;
        logic [2:0] pl;
        bit to;
        wr_req = 1'b1; rd_req = 1'b0;
        for (int i = 0; i < NPG - 1; i++) begin
            m_decide(0, 1, 0, k, p);
            do_op($urandom_range(0, 2), $urandom_range(0, 3), 0, ok, op, pl, to);
            m_commit(k);
            total++;
            if (to || ok !== 2'(k) || op !== AW'(p) || pl !== m_pulses(k) || level !== 4'(m_level)) begin
                bad++;
                $display("FAIL fill_write%0d kind/page/pulses/level got=%0d/%0d/%b/%0d exp=%0d/%0d/%b/%0d to=%0b",
                         i, ok, op, pl, level, k, p, m_pulses(k), m_level, to);
            end
        end
        total++; if (full !== 1'b1 || level !== 4'd8) begin bad++; $display("FAIL full_after_8 full/level got=%0b/%0d exp=1/8", full, level); end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (op_valid !== 1'b0) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL write_when_full got=granted exp=no grant"); end
        wr_req = 1'b0; rd_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            m_decide(0, 0, 1, k, p);
            do_op($urandom_range(0, 2), $urandom_range(0, 3), 0, ok, op, pl, to);
            m_commit(k);
            total++;
            if (to || ok !== 2'(k) || op !== AW'(p) || pl !== m_pulses(k) || level !== 4'(m_level)) begin
                bad++;
                $display("FAIL drain_read%0d kind/page/pulses/level got=%0d/%0d/%b/%0d exp=%0d/%0d/%b/%0d to=%0b",
                         i, ok, op, pl, level, k, p, m_pulses(k), m_level, to);
            end
        end
    endtask

    task automatic test_starvation;
        int k;
        int p;
        logic [1:0] ok;
        logic [AW-1:0] op;
        logic [2:0] pl;
        bit to;
        logic [1:0] want [6];
        want = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1};
        total++; if (level !== 4'd2) begin bad++; $display("FAIL starve_start_level got=%0d exp=2", level); end
        wr_req = 1'b1; rd_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            m_decide(0, 1, 1, k, p);
            do_op($urandom_range(0, 2), $urandom_range(0, 3), 0, ok, op, pl, to);
            m_commit(k);
            total++;
            if (to || ok !== want[i] || ok !== 2'(k) || op !== AW'(p) || pl !== m_pulses(k) || level !== 4'(m_level)) begin
                bad++;
                $display("FAIL starve_grant%0d kind/page/pulses/level got=%0d/%0d/%b/%0d exp=%0d/%0d/%b/%0d to=%0b",
                         i, ok, op, pl, level, want[i], p, m_pulses(k), m_level, to);
            end
            if (i == 0) begin
                total++; if (op !== '0) begin bad++; $display("FAIL wr_ptr_wrap got=%0d exp=0", op); end
            end
        end
    endtask

    task automatic test_refresh_first;
        int k;
        int p;
        logic [1:0] ok;
        logic [AW-1:0] op;
        logic [2:0] pl;
        bit to;
        ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        m_decide(1, 1, 1, k, p);
        do_op(1, 2, 0, ok, op, pl, to);
        m_commit(k);
        total++; if (to || ok !== 2'd3 || op !== '0) begin bad++; $display("FAIL refresh_first kind/page got=%0d/%0d exp=3/0 to=%0b", ok, op, to); end
        total++; if (pl !== 3'b100 || level !== 4'(m_level)) begin bad++; $display("FAIL ref_ack pulses/level got=%b/%0d exp=100/%0d", pl, level, m_level); end
        ref_req = 1'b0;
        m_decide(0, 1, 1, k, p);
        do_op(0, 1, 0, ok, op, pl, to);
        m_commit(k);
        total++;
        if (to || ok !== 2'd1 || ok !== 2'(k) || op !== AW'(p) || pl !== 3'b001 || level !== 4'(m_level)) begin
            bad++;
            $display("FAIL after_refresh kind/page/pulses/level got=%0d/%0d/%b/%0d exp=1/%0d/001/%0d to=%0b",
                     ok, op, pl, level, p, m_level, to);
        end
    endtask

    task automatic test_abandon;
        int k;
        int p;
        int n;
        logic [1:0] ok;
        logic [AW-1:0] op;
        logic [2:0] pl;
        bit to;
        bit seen;
        wr_req = 1'b0; rd_req = 1'b1; ref_req = 1'b0;
        m_decide(0, 0, 1, k, p);
        n = 0;
        while (op_valid !== 1'b1 && n < 50) begin tick(); n++; end
        total++; if (op_valid !== 1'b1 || op_kind !== 2'd2 || op_page !== AW'(p)) begin bad++; $display("FAIL abandon_issue valid/kind/page got=%0b/%0d/%0d exp=1/2/%0d", op_valid, op_kind, op_page, p); end
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        tick();
        ctl_rfo = 1'b0;
        tick();
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (op_valid !== 1'b0 || rd_done !== 1'b0) seen = 1'b1;
            tick();
        end
        total++; if (seen) begin bad++; $display("FAIL abandon_quiet valid_or_rd_done got=1 exp=0"); end
        total++; if (level !== 4'(m_level) || err !== 1'b0) begin bad++; $display("FAIL abandon_level/err got=%0d/%0b exp=%0d/0", level, err, m_level); end
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        total++; if (err !== 1'b1 || rd_done !== 1'b0 || level !== 4'(m_level)) begin bad++; $display("FAIL stray_done err/rd_done/level got=%0b/%0b/%0d exp=1/0/%0d", err, rd_done, level, m_level); end
        ctl_rfo = 1'b1;
        m_decide(0, 0, 1, k, p);
        do_op(1, 1, 1, ok, op, pl, to);
        m_commit(k);
        total++;
        if (to || ok !== 2'd2 || op !== AW'(p) || pl !== 3'b010 || level !== 4'(m_level)) begin
            bad++;
            $display("FAIL reissue_read kind/page/pulses/level got=%0d/%0d/%b/%0d exp=2/%0d/010/%0d to=%0b",
                     ok, op, pl, level, p, m_level, to);
        end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%0b exp=1", err); end
    endtask

    task automatic test_random;
        int k;
        int p;
        bit r;
        bit w;
        bit d;
        bit seen;
        logic [1:0] ok;
        logic [AW-1:0] op;
        logic [2:0] pl;
        bit to;
        for (int i = 0; i < 80; i++) begin
            r = ($urandom_range(0, 7) == 0);
            w = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            ref_req = r; wr_req = w; rd_req = d;
            m_decide(r, w, d, k, p);
            if (k == 0) begin
                seen = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    tick();
                    if (op_valid !== 1'b0) seen = 1'b1;
                end
                total++; if (seen) begin bad++; $display("FAIL rnd%0d idle_grant got=granted exp=none", i); end
            end else begin
                do_op($urandom_range(0, 2), $urandom_range(0, 4), 0, ok, op, pl, to);
                m_commit(k);
                total++;
                if (to || ok !== 2'(k) || op !== AW'(p) || pl !== m_pulses(k) || level !== 4'(m_level)
                    || full !== (m_level == NPG) || empty !== (m_level == 0)) begin
                    bad++;
                    $display("FAIL rnd%0d kind/page/pulses/level/full/empty got=%0d/%0d/%b/%0d/%0b/%0b exp=%0d/%0d/%b/%0d/%0b/%0b to=%0b",
                             i, ok, op, pl, level, full, empty, k, p, m_pulses(k), m_level,
                             (m_level == NPG), (m_level == 0), to);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_wrap();
        test_starvation();
        test_refresh_first();
        test_abandon();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
